// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: one req/ack transaction per load/store,
// byte-lane alignment of store data, pipeline stall until the access completes.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic [31:0] M_ALUanswer,
    input  logic [31:0] M_WriteData,
    input  logic [1:0]  M_store_option,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] M_Dout,
    output logic        mem_stall,
    output logic        addr_error,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [31:0]      r_dout;
    logic             r_berr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_access;
    logic             w_is_store;
    logic             w_misalign;
    logic             w_start;
    logic             w_cnt_last;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;

    assign w_access   = M_MemRead | M_MemWrite;
    assign w_is_store = M_MemWrite;
    assign w_start    = (r_state == IDLE) && w_access && !w_misalign;
    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_timeout  = w_cnt_last && !mem_ack;

    // Size decode: option 3 is reserved and behaves as a word access.
    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = M_WriteData;
        case (M_store_option)
            2'd1: begin
                w_misalign = M_ALUanswer[0];
                w_be       = M_ALUanswer[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{M_WriteData[15:0]}};
            end
            2'd2: begin
                w_misalign = 1'b0;
                w_be       = 4'b0001 << M_ALUanswer[1:0];
                w_wdata    = {4{M_WriteData[7:0]}};
            end
            default: begin
                w_misalign = (M_ALUanswer[1:0] != 2'b00);
                w_be       = 4'b1111;
                w_wdata    = M_WriteData;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = BUSY;
            BUSY:    if (mem_ack || w_timeout) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Gated by Reset so the stall releases the instant reset is asserted.
    always_comb begin
        mem_stall  = 1'b0;
        addr_error = 1'b0;
        if (Reset) begin
            mem_stall  = w_start || (r_state == BUSY);
            addr_error = (r_state == IDLE) && w_access && w_misalign;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_dout  <= '0;
            r_berr  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= w_is_store;
                        r_addr  <= {M_ALUanswer[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_is_store ? w_be : 4'b1111;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) r_dout <= mem_rdata;
                    end else if (w_timeout) begin
                        r_req  <= 1'b0;
                        r_berr <= 1'b1;
                        if (!r_we) r_dout <= '0;
                    end
                end
                DONE: begin
                    r_cnt  <= '0;
                    r_berr <= 1'b0;
                end
                default: begin
                    r_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign M_Dout    = r_dout;
    assign bus_error = r_berr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit: vectors drive accesses, an expected-result
// queue is filled at issue time and drained when the unit reaches DONE.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        Clk;
    logic        Reset;
    logic        M_MemRead;
    logic        M_MemWrite;
    logic [31:0] M_ALUanswer;
    logic [31:0] M_WriteData;
    logic [1:0]  M_store_option;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] M_Dout;
    logic        mem_stall;
    logic        addr_error;
    logic        bus_error;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .M_MemRead      (M_MemRead),
        .M_MemWrite     (M_MemWrite),
        .M_ALUanswer    (M_ALUanswer),
        .M_WriteData    (M_WriteData),
        .M_store_option (M_store_option),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .M_Dout         (M_Dout),
        .mem_stall      (mem_stall),
        .addr_error     (addr_error),
        .bus_error      (bus_error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  opt;
        int          ack_at;
        logic [31:0] rdata;
        logic        aerr;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        berr;
        int          req;
        int          stall;
    } exp_t;

    vec_t        vecs[18];
    exp_t        sbq[$];
    logic [31:0] m_dout;
    int          errors;
    int          checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [1:0] opt, input int ack_at,
                                input logic [31:0] rdata, input logic aerr, input logic [31:0] ea,
                                input logic [3:0] ebe, input logic [31:0] ewd, input logic ewe);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.opt = opt;
        v.ack_at = ack_at; v.rdata = rdata; v.aerr = aerr;
        v.e_addr = ea; v.e_be = ebe; v.e_wdata = ewd; v.e_we = ewe;
        return v;
    endfunction

    task automatic idle_inputs();
        M_MemRead = 1'b0; M_MemWrite = 1'b0; M_ALUanswer = '0;
        M_WriteData = '0; M_store_option = 2'd0;
    endtask

    // Called on a negedge with the unit in IDLE; returns on a negedge back in IDLE.
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   stalls;
        int   reqs;
        int   idx;
        int   busy;
        bit   done;
        M_MemRead = v.rd; M_MemWrite = v.wr; M_ALUanswer = v.addr;
        M_WriteData = v.wd; M_store_option = v.opt;
        #1;
        chk("addr_error", {31'b0, addr_error}, {31'b0, v.aerr});
        if (v.aerr) begin
            chk("stall_misalign", {31'b0, mem_stall}, 32'd0);
            @(posedge Clk); #1;
            chk("req_misalign", {31'b0, mem_req}, 32'd0);
            chk("dout_misalign", M_Dout, m_dout);
            idle_inputs();
            @(negedge Clk);
            return;
        end
        chk("stall_idle", {31'b0, mem_stall}, 32'd1);
        e.berr = (v.ack_at < 0);
        if (v.rd && !v.wr) m_dout = e.berr ? 32'd0 : v.rdata;
        e.dout  = m_dout;
        busy    = e.berr ? TO : v.ack_at + 1;
        e.req   = busy;
        e.stall = busy + 1;
        sbq.push_back(e);

        stalls = 1; reqs = 0; idx = 0; done = 1'b0;
        while (!done) begin
            @(negedge Clk);
            if (!mem_stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req) reqs++;
                if (idx == 0) begin
                    chk("mem_addr", mem_addr, v.e_addr);
                    chk("mem_be", {28'b0, mem_be}, {28'b0, v.e_be});
                    chk("mem_we", {31'b0, mem_we}, {31'b0, v.e_we});
                    if (v.e_we) chk("mem_wdata", mem_wdata, v.e_wdata);
                end
                mem_ack   = (idx == v.ack_at);
                mem_rdata = mem_ack ? v.rdata : $urandom;
                idx++;
                if (idx > 40) begin
                    checks++; errors++;
                    $display("FAIL stall_bound: still stalled after %0d cycles, limit 40", idx);
                    done = 1'b1;
                end
            end
        end
        // DONE cycle: results visible, a stray ack here must be ignored.
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got no expected entry, required one");
        end else begin
            got = sbq.pop_front();
            chk("dout_done", M_Dout, got.dout);
            chk("bus_error_done", {31'b0, bus_error}, {31'b0, got.berr});
            chk("req_cycles", reqs, got.req);
            chk("stall_cycles", stalls, got.stall);
            chk("req_done", {31'b0, mem_req}, 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_0F0F;
        @(negedge Clk);
        mem_ack = 1'b0;
        chk("dout_after_done", M_Dout, m_dout);
        chk("req_after_done", {31'b0, mem_req}, 32'd0);
        chk("bus_error_pulse", {31'b0, bus_error}, 32'd0);
    endtask

    initial begin
        errors = 0; checks = 0; m_dout = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        idle_inputs();
        Reset = 1'b1;
        #2 Reset = 1'b0;

        vecs[0]  = mk(1, 0, 32'h100, 32'h0,        2'd0,  2, 32'hCAFEF00D, 0, 32'h100, 4'b1111, 32'h0,        0);
        vecs[1]  = mk(0, 1, 32'h203, 32'h000000A5, 2'd2,  0, 32'h0,        0, 32'h200, 4'b1000, 32'hA5A5A5A5, 1);
        vecs[2]  = mk(0, 1, 32'h302, 32'h00001234, 2'd1,  1, 32'h0,        0, 32'h300, 4'b1100, 32'h12341234, 1);
        vecs[3]  = mk(0, 1, 32'h301, 32'h00001234, 2'd1,  0, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        0);
        vecs[4]  = mk(0, 1, 32'h404, 32'hDEADBEEF, 2'd0,  0, 32'h0,        0, 32'h404, 4'b1111, 32'hDEADBEEF, 1);
        vecs[5]  = mk(0, 1, 32'h406, 32'h11111111, 2'd0,  0, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        0);
        vecs[6]  = mk(0, 1, 32'h407, 32'h22222222, 2'd3,  0, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        0);
        vecs[7]  = mk(0, 1, 32'h408, 32'h0F0F0F0F, 2'd3,  3, 32'h0,        0, 32'h408, 4'b1111, 32'h0F0F0F0F, 1);
        vecs[8]  = mk(0, 1, 32'h501, 32'h11223344, 2'd2,  0, 32'h0,        0, 32'h500, 4'b0010, 32'h44444444, 1);
        vecs[9]  = mk(0, 1, 32'h500, 32'hAABBCCDD, 2'd1,  0, 32'h0,        0, 32'h500, 4'b0011, 32'hCCDDCCDD, 1);
        vecs[10] = mk(1, 1, 32'h600, 32'h00000055, 2'd2,  0, 32'h0,        0, 32'h600, 4'b0001, 32'h55555555, 1);
        vecs[11] = mk(1, 0, 32'h603, 32'h0,        2'd2,  4, 32'h12345678, 0, 32'h600, 4'b1111, 32'h0,        0);
        vecs[12] = mk(1, 0, 32'h001, 32'h0,        2'd1,  0, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        0);
        vecs[13] = mk(1, 0, 32'h700, 32'h0,        2'd0, -1, 32'h0,        0, 32'h700, 4'b1111, 32'h0,        0);
        vecs[14] = mk(0, 1, 32'h800, 32'h00000099, 2'd0, -1, 32'h0,        0, 32'h800, 4'b1111, 32'h00000099, 1);
        vecs[15] = mk(1, 0, 32'h704, 32'h0,        2'd0, 15, 32'h0BADCAFE, 0, 32'h704, 4'b1111, 32'h0,        0);
        vecs[16] = mk(1, 0, 32'h708, 32'h0,        2'd0,  0, 32'h13579BDF, 0, 32'h708, 4'b1111, 32'h0,        0);
        vecs[17] = mk(1, 0, 32'h70A, 32'h0,        2'd1,  0, 32'hFEEDFACE, 0, 32'h708, 4'b1111, 32'h0,        0);

        @(negedge Clk);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_dout", M_Dout, 32'd0);
        chk("rst_bus_error", {31'b0, bus_error}, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Reset asserted mid-BUSY with the load still presented.
        M_MemRead = 1'b1; M_MemWrite = 1'b0; M_ALUanswer = 32'h900; M_store_option = 2'd0;
        repeat (4) @(negedge Clk);
        chk("req_before_reset", {31'b0, mem_req}, 32'd1);
        chk("stall_before_reset", {31'b0, mem_stall}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("req_async_reset", {31'b0, mem_req}, 32'd0);
        chk("stall_async_reset", {31'b0, mem_stall}, 32'd0);
        idle_inputs();
        m_dout = '0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("dout_after_reset", M_Dout, m_dout);
        chk("req_after_reset", {31'b0, mem_req}, 32'd0);
        chk("bus_error_after_reset", {31'b0, bus_error}, 32'd0);

        // Unit must be usable again from IDLE after the reset.
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
